alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Wishbone pipeline master that runs one ALU operation per request on the 8-bit ALU slave.
//  It accepts {op, a, b} on a valid/ready port and writes A (0x00) and B (0x01).
//  It then reads the op address (0x80+op) and the flags (0x02), and returns {result, flags, err}.
//  It sits between the CPU core's execute stage and the ALU bus, with one bus transaction in flight at a time.
// PARAMETERS
//  ACK_TIMEOUT  16  max cycles from strobe acceptance to ack before abort; must be >= 2
//  OP_W         1   width of i_req_op; read address = 8'h80 + i_req_op
// PORTS
//  i_clk         in   1     system clock
//  reset         in   1     synchronous, active-high reset
//  i_req_valid   in   1     request valid
//  o_req_ready   out  1     request ready; high only in IDLE
//  i_req_op      in   OP_W  operation select (0 add, 1 add-with-carry)
//  i_req_a       in   8     operand A
//  i_req_b       in   8     operand B
//  o_rsp_valid   out  1     response valid; held until accepted
//  i_rsp_ready   in   1     response ready
//  o_rsp_result  out  8     data returned by the op-address read
//  o_rsp_flags   out  8     data returned by the 0x02 read
//  o_rsp_err     out  1     1 = a bus phase timed out; result and flags are invalid
//  o_wb_stb      out  1     bus strobe
//  o_wb_we       out  1     bus write enable
//  o_wb_addr     out  8     bus address
//  o_wb_data     out  8     bus write data
//  i_wb_ack      in   1     slave acknowledge
//  i_wb_stall    in   1     slave stall
//  i_wb_data     in   8     slave read data
// BEHAVIOUR
//  Reset (sync, high): state IDLE; all outputs and registers 0 except o_req_ready=1.
//   Reset wins over every other event, including mid-operation. o_wb_stb drops at that edge.
//   Any outstanding ack after reset is ignored.
//  Request accept: i_req_valid & o_req_ready at a clock edge.
//   op, a and b are latched and the FSM moves to WR_A. o_req_ready=0 from the next cycle.
//  States: IDLE -> WR_A -> WR_B -> RD_OP -> RD_FLG -> RESP -> IDLE.
//   | addr/we per state: WR_A 0x00/1 (data=a); WR_B 0x01/1 (data=b); RD_OP 0x80+op/0; RD_FLG 0x02/0.
//  Each bus state has two sub-phases, REQ and WAIT:
//   REQ: stb=1 and addr/we/data stable. The phase is accepted on the first edge with stb & !i_wb_stall.
//    Stall cycles are unbounded and are not counted toward the timeout.
//   WAIT: stb=0; the timeout counter starts at 0 the cycle after acceptance.
//    i_wb_ack moves to the next state's REQ on the following cycle, so there is 1 idle bus cycle between phases.
//    An ack in the same cycle as acceptance is impossible by pipeline rules and is ignored.
//  Read capture: on the ack edge, i_wb_data goes to o_rsp_result (RD_OP) or o_rsp_flags (RD_FLG).
//  Timeout: if the counter reaches ACK_TIMEOUT-1 in WAIT with no ack, the FSM goes straight to RESP with err=1.
//   Result and flags are then forced to 0.
//  RESP: o_rsp_valid=1 and the response is held stable until i_rsp_ready.
//   On accept the FSM returns to IDLE and o_req_ready=1 on the next cycle.
//   A new request cannot be accepted in the RESP-accept cycle.
//  Latency with no stall and 1-cycle ack: request accepted at edge 0 -> o_rsp_valid high at edge 8.
//   Each phase takes 2 cycles (REQ and WAIT).
//  o_wb_data is 0 whenever we=0 or stb=0. o_wb_addr and o_wb_we hold their last value while stb=0.
//  The strobe is never reasserted for a phase that has already been accepted, so each address sees exactly one write or read.
// TESTING
//  1 add: op=0, a=0x05, b=0x03; slave model returns 0x08 / flags 0x02.
//    -> bus order 0x00 W05, 0x01 W03, 0x80 R, 0x02 R; rsp result=0x08, flags=0x02, err=0; valid at edge 8.
//  2 stall: op=1, a=0xFF, b=0x00; i_wb_stall=1 for 3 cycles on WR_B.
//    -> stb held with addr 0x01 and data 0x00 for those cycles; single write accepted; response 3 cycles later than baseline.
//  3 timeout: ACK_TIMEOUT=16; slave never acks RD_OP.
//    -> rsp err=1, result=0, flags=0, valid 16 cycles after RD_OP acceptance; no RD_FLG strobe.
//  4 backpressure: hold i_rsp_ready=0 for 5 cycles while i_req_valid=1 with a new request.
//    -> response stable for 5 cycles; o_req_ready=0 throughout; the new request is accepted in the cycle after RESP accept.
//  5 reset mid-op: assert reset in WR_B WAIT, then ack arrives the cycle after.
//    -> next cycle stb=0, o_req_ready=1, o_rsp_valid=0; the stray ack is ignored; the next request runs normally.
//  6 back-to-back: 4 requests with i_rsp_ready=1 always.
//    -> 4 responses in order; exactly 16 strobe acceptances in the bus log.

Source files
------------

// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer
//
// Purpose:
//   Bus master that runs one ALU operation per request on an 8-bit ALU slave.
//   A request {op, a, b} is taken on a valid/ready port. The sequencer then
//   runs four bus phases, one at a time:
//     - write a to 0x00
//     - write b to 0x01
//     - read the op address (0x80 + op)
//     - read the flags register (0x02)
//   It returns {result, flags, err} on a valid/ready response port.
//
//   Each bus phase has two parts:
//     - REQ : the strobe is held until the slave stops stalling.
//     - WAIT: the strobe is low and an ack is awaited, guarded by a timeout.
//   If a WAIT times out, the sequencer skips straight to the response with
//   err set and the result and flags zeroed.
//
// Parameters:
//   ACK_TIMEOUT  cycles allowed from strobe acceptance to ack (>= 2)
//   OP_W         width of the operation select
//
// Ports:
//   i_clk, reset                clock, synchronous active-high reset
//   i_req_valid / o_req_ready   request handshake (ready only when idle)
//   i_req_op, i_req_a, i_req_b  operation select and operands
//   o_rsp_valid / i_rsp_ready   response handshake (held until accepted)
//   o_rsp_result, o_rsp_flags   captured read data
//   o_rsp_err                   a bus phase timed out
//   o_wb_stb, o_wb_we           bus strobe, write enable
//   o_wb_addr, o_wb_data        bus address, write data
//   i_wb_ack, i_wb_stall        slave acknowledge, slave stall
//   i_wb_data                   slave read data
// ----------------------------------------------------------------------------
module alu_sequencer #(
   parameter int ACK_TIMEOUT = 16,
   parameter int OP_W        = 1
) (
   input  logic            i_clk,
   input  logic            reset,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic [OP_W-1:0] i_req_op,
   input  logic [7:0]      i_req_a,
   input  logic [7:0]      i_req_b,
   output logic            o_rsp_valid,
   input  logic            i_rsp_ready,
   output logic [7:0]      o_rsp_result,
   output logic [7:0]      o_rsp_flags,
   output logic            o_rsp_err,
   output logic            o_wb_stb,
   output logic            o_wb_we,
   output logic [7:0]      o_wb_addr,
   output logic [7:0]      o_wb_data,
   input  logic            i_wb_ack,
   input  logic            i_wb_stall,
   input  logic [7:0]      i_wb_data
);

   localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   localparam logic [7:0] ADDR_A     = 8'h00;
   localparam logic [7:0] ADDR_B     = 8'h01;
   localparam logic [7:0] ADDR_FLAGS = 8'h02;
   localparam logic [7:0] ADDR_OPS   = 8'h80;

   typedef enum logic [3:0] {
      IDLE,
      WRA_REQ,
      WRA_WAIT,
      WRB_REQ,
      WRB_WAIT,
      RDOP_REQ,
      RDOP_WAIT,
      RDFLG_REQ,
      RDFLG_WAIT,
      RESP
   } state_t;

   state_t            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [7:0]        a_q, a_d;
   logic [7:0]        b_q, b_d;
   logic [7:0]        addr_q, addr_d;
   logic              we_q, we_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        result_q, result_d;
   logic [7:0]        flags_q, flags_d;
   logic              err_q, err_d;

   // State register. Reset overrides everything, so an in-flight phase is
   // abandoned and its late ack lands in IDLE, where acks are never looked at.
   always_ff @(posedge i_clk) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         err_q    <= err_d;
      end
   end

   // Next-state logic.
   //
   // Address and write enable are loaded at the moment a REQ state is
   // entered. They then stay put through WAIT, so the bus keeps showing the
   // last address while the strobe is low.
   //
   // The ack counter only runs in WAIT. Stall cycles in REQ therefore never
   // eat into the timeout budget.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      addr_d   = addr_q;
      we_d     = we_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flags_d  = flags_q;
      err_d    = err_q;

      unique case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               op_d     = i_req_op;
               a_d      = i_req_a;
               b_d      = i_req_b;
               result_d = '0;
               flags_d  = '0;
               err_d    = 1'b0;
               addr_d   = ADDR_A;
               we_d     = 1'b1;
               state_d  = WRA_REQ;
            end
         end

         WRA_REQ, WRB_REQ, RDOP_REQ, RDFLG_REQ: begin
            if (!i_wb_stall) begin
               cnt_d   = '0;
               state_d = state_t'(state_q + 4'd1);
            end
         end

         WRA_WAIT, WRB_WAIT, RDOP_WAIT, RDFLG_WAIT: begin
            if (i_wb_ack) begin
               unique case (state_q)
                  WRA_WAIT: begin
                     addr_d  = ADDR_B;
                     we_d    = 1'b1;
                     state_d = WRB_REQ;
                  end
                  WRB_WAIT: begin
                     addr_d  = ADDR_OPS + 8'(op_q);
                     we_d    = 1'b0;
                     state_d = RDOP_REQ;
                  end
                  RDOP_WAIT: begin
                     result_d = i_wb_data;
                     addr_d   = ADDR_FLAGS;
                     we_d     = 1'b0;
                     state_d  = RDFLG_REQ;
                  end
                  default: begin
                     flags_d = i_wb_data;
                     state_d = RESP;
                  end
               endcase
            end else if (cnt_q == CNT_LAST) begin
               result_d = '0;
               flags_d  = '0;
               err_d    = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RESP: begin
            if (i_rsp_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the registered state only.
   //
   // Write data is driven solely while a write strobe is up. It is zero
   // otherwise, so stale operands never appear on the bus.
   always_comb begin
      o_req_ready  = (state_q == IDLE);
      o_rsp_valid  = (state_q == RESP);
      o_rsp_result = result_q;
      o_rsp_flags  = flags_q;
      o_rsp_err    = err_q;
      o_wb_we      = we_q;
      o_wb_addr    = addr_q;
      o_wb_stb     = 1'b0;
      o_wb_data    = 8'h00;

      unique case (state_q)
         WRA_REQ: begin
            o_wb_stb  = 1'b1;
            o_wb_data = a_q;
         end
         WRB_REQ: begin
            o_wb_stb  = 1'b1;
            o_wb_data = b_q;
         end
         RDOP_REQ, RDFLG_REQ: begin
            o_wb_stb = 1'b1;
         end
         default: begin
            o_wb_stb = 1'b0;
         end
      endcase
   end

endmodule
